// File: rtl/mat_pkg.sv
// Shared constants and state encoding for the matrix-multiply result writer.
//   NBIT    : accumulator/result word width (Q21.11 signed)
//   DIM     : matrix dimension; DIM*DIM complex results per run
//   ADDRESS : result RAM address width (interleaved real/imag words)
package mat_pkg;

  localparam int unsigned NBIT    = 32;
  localparam int unsigned DIM     = 32;
  localparam int unsigned ADDRESS = $clog2((DIM * DIM * 2) - 1);

  // Fixed-point layout of the accumulator word, bits [20:-11]
  localparam int unsigned Q_INT  = 21;
  localparam int unsigned Q_FRAC = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } wr_state_e;

endpackage

// File: rtl/mat_result_writer_if.sv
// Result-path bundle between the MAC datapath and the result RAM writer.
//   flagR_wr/flagI_wr : real/imag result-valid levels from the MAC
//   accR_wr/accI_wr   : real/imag accumulator words, stable while the flag is high
//   wr_*              : result RAM write strobe, address and data
//   cntR_wr/cntI_wr   : results written so far; done_wr/err_wr : status
interface mat_result_writer_if #(
  parameter int unsigned NBIT    = 32,
  parameter int unsigned ADDRESS = 11
);

  logic               flagR_wr;
  logic               flagI_wr;
  logic [NBIT-1:0]    accR_wr;
  logic [NBIT-1:0]    accI_wr;
  logic               wr_en_wr;
  logic [ADDRESS-1:0] wr_addr_wr;
  logic [NBIT-1:0]    wr_data_wr;
  logic [ADDRESS-1:0] cntR_wr;
  logic [ADDRESS-1:0] cntI_wr;
  logic               done_wr;
  logic               err_wr;

  // Source side: MAC results in, RAM writes and status observed
  modport master (
    output flagR_wr, flagI_wr, accR_wr, accI_wr,
    input  wr_en_wr, wr_addr_wr, wr_data_wr, cntR_wr, cntI_wr, done_wr, err_wr
  );

  // Writer side
  modport slave (
    input  flagR_wr, flagI_wr, accR_wr, accI_wr,
    output wr_en_wr, wr_addr_wr, wr_data_wr, cntR_wr, cntI_wr, done_wr, err_wr
  );

endinterface

// File: rtl/flag_edge_capture.sv
// Rising-edge detector on a result-valid level plus a sample register for
// the matching accumulator word.
//   clk, rst : clock and synchronous active-high reset
//   flag     : result-valid level
//   hold     : freezes the sample register (a parked value must not be overwritten)
//   acc      : accumulator word
//   edge_c   : one-cycle pulse on the rising edge of flag
//   data_c   : accumulator on a fresh capture, otherwise the held sample
module flag_edge_capture #(
  parameter int unsigned NBIT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flag,
  input  logic            hold,
  input  logic [NBIT-1:0] acc,
  output logic            edge_c,
  output logic [NBIT-1:0] data_c
);

  logic            flag_d;
  logic [NBIT-1:0] data_q;
  logic            cap_c;

  assign edge_c = flag & ~flag_d;
  assign cap_c  = edge_c & ~hold;
  assign data_c = cap_c ? acc : data_q;

  // Flag delay and sample register
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_d <= 1'b0;
      data_q <= '0;
    end else begin
      flag_d <= flag;
      if (cap_c) begin
        data_q <= acc;
      end
    end
  end

endmodule

// File: rtl/mat_result_writer.sv
// Captures complex matrix-multiply results on the MAC's flag edges and writes
// them to the result RAM interleaved (real at 2n, imag at 2n+1). Raises done
// after DIM*DIM complex results.
//   clk_wr   : clock
//   rst_wr   : synchronous active-high reset
//   start_wr : one-cycle pulse, clears counters/error and starts collecting
//   bus      : result bundle (flags/accumulators in, RAM write and status out)
module mat_result_writer
  import mat_pkg::*;
#(
  parameter int unsigned NBIT    = mat_pkg::NBIT,
  parameter int unsigned DIM     = mat_pkg::DIM,
  parameter int unsigned ADDRESS = $clog2((DIM * DIM * 2) - 1)
) (
  input  logic                clk_wr,
  input  logic                rst_wr,
  input  logic                start_wr,
  mat_result_writer_if.slave  bus
);

  localparam logic [ADDRESS-1:0] FULL = ADDRESS'(DIM * DIM);
  localparam logic [ADDRESS-1:0] ONE  = ADDRESS'(1);

  wr_state_e          state, state_n;
  logic [ADDRESS-1:0] cnt_r, cnt_r_n;
  logic [ADDRESS-1:0] cnt_i, cnt_i_n;
  logic               pend, pend_n;
  logic               err, err_n;
  logic               done, done_n;
  logic               wr_en, wr_en_n;
  logic [ADDRESS-1:0] wr_addr, wr_addr_n;
  logic [NBIT-1:0]    wr_data, wr_data_n;

  logic               edge_r_c, edge_i_c;
  logic [NBIT-1:0]    data_r_c, data_i_c;
  logic               real_wr_c, pend_wr_c;

  // Real path never parks a value
  flag_edge_capture #(.NBIT(NBIT)) u_cap_r (
    .clk    (clk_wr),
    .rst    (rst_wr),
    .flag   (bus.flagR_wr),
    .hold   (1'b0),
    .acc    (bus.accR_wr),
    .edge_c (edge_r_c),
    .data_c (data_r_c)
  );

  // Imag sample register doubles as the one-entry pending slot
  flag_edge_capture #(.NBIT(NBIT)) u_cap_i (
    .clk    (clk_wr),
    .rst    (rst_wr),
    .flag   (bus.flagI_wr),
    .hold   (pend),
    .acc    (bus.accI_wr),
    .edge_c (edge_i_c),
    .data_c (data_i_c)
  );

  // Real writes take the port; a parked imag waits for a free cycle
  assign real_wr_c = (state == COLLECT) & ~start_wr & edge_r_c & (cnt_r != FULL);
  assign pend_wr_c = (state == COLLECT) & ~start_wr & pend & ~real_wr_c;

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    cnt_r_n   = cnt_r;
    cnt_i_n   = cnt_i;
    pend_n    = pend;
    err_n     = err;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;

    case (state)
      IDLE: begin
        if (start_wr) begin
          state_n = COLLECT;
          cnt_r_n = '0;
          cnt_i_n = '0;
          pend_n  = 1'b0;
          err_n   = 1'b0;
        end else if (edge_r_c | edge_i_c) begin
          err_n = 1'b1;
        end
      end

      COLLECT: begin
        if (start_wr) begin
          cnt_r_n = '0;
          cnt_i_n = '0;
          pend_n  = 1'b0;
          err_n   = 1'b0;
        end else begin
          if (edge_r_c) begin
            if (real_wr_c) begin
              wr_en_n   = 1'b1;
              wr_addr_n = {cnt_r[ADDRESS-2:0], 1'b0};
              wr_data_n = data_r_c;
              cnt_r_n   = cnt_r + ONE;
            end else begin
              err_n = 1'b1;
            end
          end

          if (pend_wr_c) begin
            wr_en_n   = 1'b1;
            wr_addr_n = {cnt_i[ADDRESS-2:0], 1'b1};
            wr_data_n = data_i_c;
            cnt_i_n   = cnt_i + ONE;
            pend_n    = 1'b0;
          end

          if (edge_i_c) begin
            if ((cnt_i == FULL) || pend) begin
              err_n = 1'b1;
            end else if (real_wr_c) begin
              pend_n = 1'b1;
            end else begin
              wr_en_n   = 1'b1;
              wr_addr_n = {cnt_i[ADDRESS-2:0], 1'b1};
              wr_data_n = data_i_c;
              cnt_i_n   = cnt_i + ONE;
            end
          end

          if ((cnt_r == FULL) && (cnt_i == FULL) && !pend) begin
            state_n = DONE;
          end
        end
      end

      DONE: begin
        if (start_wr) begin
          state_n = COLLECT;
          cnt_r_n = '0;
          cnt_i_n = '0;
          pend_n  = 1'b0;
          err_n   = 1'b0;
        end else if (edge_r_c | edge_i_c) begin
          err_n = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    done_n = (state_n == DONE);
  end

  // State and output registers
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state   <= IDLE;
      cnt_r   <= '0;
      cnt_i   <= '0;
      pend    <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_n;
      cnt_r   <= cnt_r_n;
      cnt_i   <= cnt_i_n;
      pend    <= pend_n;
      err     <= err_n;
      done    <= done_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
    end
  end

  assign bus.wr_en_wr   = wr_en;
  assign bus.wr_addr_wr = wr_addr;
  assign bus.wr_data_wr = wr_data;
  assign bus.cntR_wr    = cnt_r;
  assign bus.cntI_wr    = cnt_i;
  assign bus.done_wr    = done;
  assign bus.err_wr     = err;

endmodule

// File: tb/tb_mat_result_writer.sv
// Directed bench for mat_result_writer built with DIM=4 (16 complex results).
module tb_mat_result_writer;

  localparam int unsigned NB = 32;
  localparam int unsigned DM = 4;
  localparam int unsigned AW = $clog2((DM * DM * 2) - 1);

  typedef struct {
    logic          st;
    logic          fr;
    logic          fi;
    logic [NB-1:0] ar;
    logic [NB-1:0] ai;
    logic          en;
    logic [AW-1:0] addr;
    logic [NB-1:0] data;
    logic [AW-1:0] cr;
    logic [AW-1:0] ci;
    logic          err;
    logic          done;
  } vec_t;

  logic clk_tb;
  logic rst_tb;
  logic start_tb;

  int n_chk;
  int n_err;

  vec_t tbl[$];

  mat_result_writer_if #(.NBIT(NB), .ADDRESS(AW)) bus_tb ();

  mat_result_writer #(.NBIT(NB), .DIM(DM), .ADDRESS(AW)) u_dut (
    .clk_wr   (clk_tb),
    .rst_wr   (rst_tb),
    .start_wr (start_tb),
    .bus      (bus_tb)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic drive(input logic st, input logic fr, input logic fi,
                       input logic [NB-1:0] ar, input logic [NB-1:0] ai);
    start_tb        = st;
    bus_tb.flagR_wr = fr;
    bus_tb.flagI_wr = fi;
    bus_tb.accR_wr  = ar;
    bus_tb.accI_wr  = ai;
  endtask

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_row(input string nm, input vec_t v);
    chk({nm, ".en"},   NB'(bus_tb.wr_en_wr), NB'(v.en));
    chk({nm, ".cntR"}, NB'(bus_tb.cntR_wr),  NB'(v.cr));
    chk({nm, ".cntI"}, NB'(bus_tb.cntI_wr),  NB'(v.ci));
    chk({nm, ".err"},  NB'(bus_tb.err_wr),   NB'(v.err));
    chk({nm, ".done"}, NB'(bus_tb.done_wr),  NB'(v.done));
    if (v.en) begin
      chk({nm, ".addr"}, NB'(bus_tb.wr_addr_wr), NB'(v.addr));
      chk({nm, ".data"}, bus_tb.wr_data_wr, v.data);
    end
  endtask

  task automatic add(input logic st, input logic fr, input logic fi,
                     input logic [NB-1:0] ar, input logic [NB-1:0] ai,
                     input logic en, input int addr, input logic [NB-1:0] data,
                     input int cr, input int ci, input logic err, input logic done);
    vec_t v;
    v.st = st; v.fr = fr; v.fi = fi; v.ar = ar; v.ai = ai;
    v.en = en; v.addr = AW'(addr); v.data = data;
    v.cr = AW'(cr); v.ci = AW'(ci); v.err = err; v.done = done;
    tbl.push_back(v);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;

    // st fr fi  ar            ai             en addr data          cR cI err done
    add(1, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,          0, 0, 0, 0);
    add(0, 1, 0, 32'h0000_0800, 32'h0,         1, 0, 32'h0000_0800,  1, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      add(0, 1, 0, 32'h0000_0800, 32'h0,       0, 0, 32'h0,          1, 0, 0, 0);
    add(0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,          1, 0, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,          0, 0, 0, 0);
    add(0, 1, 0, 32'h0000_1000, 32'h0,         1, 0, 32'h0000_1000,  1, 0, 0, 0);
    add(0, 1, 0, 32'h0000_1000, 32'h0,         0, 0, 32'h0,          1, 0, 0, 0);
    add(0, 1, 0, 32'h0000_1000, 32'h0,         0, 0, 32'h0,          1, 0, 0, 0);
    add(0, 1, 1, 32'h0000_1000, 32'hFFFF_F800, 1, 1, 32'hFFFF_F800,  1, 1, 0, 0);
    add(0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,          1, 1, 0, 0);
    add(1, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,          0, 0, 0, 0);
    add(0, 1, 1, 32'd5,         32'd7,         1, 0, 32'd5,          1, 0, 0, 0);
    add(0, 1, 1, 32'd5,         32'd7,         1, 1, 32'd7,          1, 1, 0, 0);
    add(0, 0, 0, 32'h0,         32'h0,         0, 0, 32'h0,          1, 1, 0, 0);

    // Reset state
    rst_tb = 1'b1;
    drive(0, 0, 0, '0, '0);
    tick();
    tick();
    chk("rst.en",   NB'(bus_tb.wr_en_wr),   '0);
    chk("rst.addr", NB'(bus_tb.wr_addr_wr), '0);
    chk("rst.data", bus_tb.wr_data_wr,      '0);
    chk("rst.cntR", NB'(bus_tb.cntR_wr),    '0);
    chk("rst.cntI", NB'(bus_tb.cntI_wr),    '0);
    chk("rst.err",  NB'(bus_tb.err_wr),     '0);
    chk("rst.done", NB'(bus_tb.done_wr),    '0);
    rst_tb = 1'b0;
    tick();
    chk("idle.en", NB'(bus_tb.wr_en_wr), '0);

    // Table-driven single-cycle vectors
    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].st, tbl[r].fr, tbl[r].fi, tbl[r].ar, tbl[r].ai);
      tick();
      chk_row($sformatf("row%0d", r), tbl[r]);
    end

    // Real count saturates: a 17th real edge is refused and flags an error
    drive(1, 0, 0, '0, '0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, NB'(i), '0);
      tick();
      chk($sformatf("rfull%0d.en", i),   NB'(bus_tb.wr_en_wr),   NB'(1));
      chk($sformatf("rfull%0d.addr", i), NB'(bus_tb.wr_addr_wr), NB'(2 * i));
      drive(0, 0, 0, '0, '0);
      tick();
    end
    drive(0, 1, 0, 32'hDEAD, '0);
    tick();
    chk("rfull.x.en",   NB'(bus_tb.wr_en_wr), '0);
    chk("rfull.x.err",  NB'(bus_tb.err_wr),   NB'(1));
    chk("rfull.x.cntR", NB'(bus_tb.cntR_wr),  NB'(16));
    chk("rfull.x.done", NB'(bus_tb.done_wr),  '0);
    drive(0, 0, 0, '0, '0);
    tick();

    // Full run of 16 complex results
    drive(1, 0, 0, '0, '0);
    tick();
    chk("run.err", NB'(bus_tb.err_wr), '0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, NB'(2 * i), '0);
      tick();
      chk($sformatf("run%0d.r.en", i),   NB'(bus_tb.wr_en_wr),   NB'(1));
      chk($sformatf("run%0d.r.addr", i), NB'(bus_tb.wr_addr_wr), NB'(2 * i));
      chk($sformatf("run%0d.r.data", i), bus_tb.wr_data_wr,      NB'(2 * i));
      drive(0, 0, 1, '0, NB'(2 * i + 1));
      tick();
      chk($sformatf("run%0d.i.en", i),   NB'(bus_tb.wr_en_wr),   NB'(1));
      chk($sformatf("run%0d.i.addr", i), NB'(bus_tb.wr_addr_wr), NB'(2 * i + 1));
      chk($sformatf("run%0d.i.data", i), bus_tb.wr_data_wr,      NB'(2 * i + 1));
      chk($sformatf("run%0d.i.done", i), NB'(bus_tb.done_wr),    '0);
      drive(0, 0, 0, '0, '0);
      tick();
      chk($sformatf("run%0d.gap.en", i),   NB'(bus_tb.wr_en_wr), '0);
      chk($sformatf("run%0d.gap.done", i), NB'(bus_tb.done_wr),  NB'(i == 15));
    end
    chk("run.cntR", NB'(bus_tb.cntR_wr), NB'(16));
    chk("run.cntI", NB'(bus_tb.cntI_wr), NB'(16));
    chk("run.err2", NB'(bus_tb.err_wr),  '0);

    // Edge after done: no write, sticky error, done held; start clears
    drive(0, 1, 0, 32'h1234, '0);
    tick();
    chk("late.en",   NB'(bus_tb.wr_en_wr), '0);
    chk("late.err",  NB'(bus_tb.err_wr),   NB'(1));
    chk("late.done", NB'(bus_tb.done_wr),  NB'(1));
    drive(1, 0, 0, '0, '0);
    tick();
    chk("restart.err",  NB'(bus_tb.err_wr),  '0);
    chk("restart.cntR", NB'(bus_tb.cntR_wr), '0);
    chk("restart.cntI", NB'(bus_tb.cntI_wr), '0);
    chk("restart.done", NB'(bus_tb.done_wr), '0);

    // Reset lands on the edge cycle: the write is abandoned
    drive(0, 1, 0, 32'hAAAA, '0);
    rst_tb = 1'b1;
    tick();
    rst_tb = 1'b0;
    drive(0, 0, 0, '0, '0);
    chk("rstmid.en",   NB'(bus_tb.wr_en_wr),   '0);
    chk("rstmid.addr", NB'(bus_tb.wr_addr_wr), '0);
    chk("rstmid.data", bus_tb.wr_data_wr,      '0);
    chk("rstmid.cntR", NB'(bus_tb.cntR_wr),    '0);
    chk("rstmid.err",  NB'(bus_tb.err_wr),     '0);
    chk("rstmid.done", NB'(bus_tb.done_wr),    '0);
    tick();
    chk("rstmid2.en", NB'(bus_tb.wr_en_wr), '0);
    // Back in IDLE: an edge is an error, not a write
    drive(0, 1, 0, 32'h5555, '0);
    tick();
    chk("idleedge.en",  NB'(bus_tb.wr_en_wr), '0);
    chk("idleedge.err", NB'(bus_tb.err_wr),   NB'(1));
    drive(0, 0, 0, '0, '0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
